per2axi_res_channel: RTL and testbench

- Response-side companion of the per2axi request path.
- Accepts AXI4 read-data (R) and write-response (B) beats from the AXI slave and converts them into single-cycle peripheral-interconnect response pulses toward the originating core.
- Keeps a per-ID record of the 64-bit lane (address bit 2) captured when each read is issued, so the correct 32-bit half of R data is returned.
- Sits between the AXI master port and the peripheral slave response port, fed by the request path's trans_req/trans_id/trans_add side-band.

---
 rtl/per2axi_res_channel.sv | 125 ++++++++++++
 tb/tb_per2axi_res_channel.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/per2axi_res_channel.sv
`default_nettype none
// ============================================================================
// per2axi_res_channel : AXI R/B beats -> single-cycle peripheral responses
// Revision: 1.0
// ============================================================================
module per2axi_res_channel #(
  parameter int NB_CORES       = 4,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  input  logic                      trans_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,
  output logic                      unexp_r_o
);

  localparam int NB_IDS = 2**AXI_ID_WIDTH;

  logic [NB_IDS-1:0]       lane_q, lane_d;
  logic [NB_IDS-1:0]       pend_q, pend_d;
  logic                    valid_q, valid_d;
  logic                    opc_q, opc_d;
  logic                    unexp_q, unexp_d;
  logic [PER_ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]             rdata_q, rdata_d;

  logic r_acc, b_acc, r_in_range, b_in_range, r_upper;
  logic unused_inputs;

  assign unused_inputs = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                           trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0],
                           axi_master_r_data_i[AXI_DATA_WIDTH-1:0]};

  // R always wins the response slot; B is held off while R is presented.
  assign axi_master_r_ready_o = ~rst_i;
  assign axi_master_b_ready_o = ~rst_i & ~axi_master_r_valid_i;

  assign r_acc      = axi_master_r_valid_i & axi_master_r_ready_o;
  assign b_acc      = axi_master_b_valid_i & axi_master_b_ready_o;
  assign r_in_range = 32'(axi_master_r_id_i) < PER_ID_WIDTH;
  assign b_in_range = 32'(axi_master_b_id_i) < PER_ID_WIDTH;
  // A stale lane bit from an already-retired read must not steer unexpected data.
  assign r_upper    = lane_q[axi_master_r_id_i] & pend_q[axi_master_r_id_i];

  always_comb begin
    lane_d  = lane_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    unexp_d = 1'b0;
    opc_d   = opc_q;
    id_d    = id_q;
    rdata_d = rdata_q;

    if (r_acc) begin
      unexp_d                   = ~pend_q[axi_master_r_id_i];
      pend_d[axi_master_r_id_i] = 1'b0;
      if (r_in_range) begin
        valid_d = 1'b1;
        opc_d   = axi_master_r_resp_i[1];
        id_d    = PER_ID_WIDTH'(1) << axi_master_r_id_i;
        rdata_d = r_upper ? axi_master_r_data_i[63:32] : axi_master_r_data_i[31:0];
      end
    end else if (b_acc && b_in_range) begin
      valid_d = 1'b1;
      opc_d   = axi_master_b_resp_i[1];
      id_d    = PER_ID_WIDTH'(1) << axi_master_b_id_i;
      rdata_d = 32'h0;
    end

    // Applied after the R clear so a same-cycle re-issue leaves the ID pending.
    if (trans_req_i) begin
      lane_d[trans_id_i] = trans_add_i[2];
      pend_d[trans_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      opc_q   <= 1'b0;
      unexp_q <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
    end else begin
      lane_q  <= lane_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      unexp_q <= unexp_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
    end
  end

  assign per_slave_r_valid_o = valid_q;
  assign per_slave_r_opc_o   = opc_q;
  assign per_slave_r_id_o    = id_q;
  assign per_slave_r_rdata_o = rdata_q;
  assign unexp_r_o           = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_per2axi_res_channel.sv
`default_nettype none
// ============================================================================
// tb_per2axi_res_channel : directed vector table, reset corner and random run
// Revision: 1.0
// ============================================================================
module tb_per2axi_res_channel;

  logic        clk;
  logic        rst;
  logic        r_valid_o, r_opc_o, unexp_o, r_ready_o, b_ready_o;
  logic [4:0]  r_id_o;
  logic [31:0] r_rdata_o;
  logic        treq;
  logic [2:0]  tid;
  logic [31:0] tadd;
  logic        rv, bv, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [2:0]  rid, bid;
  logic [5:0]  ruser, buser;

  int n_cmp = 0;
  int n_err = 0;

  per2axi_res_channel dut (
    .clk_i(clk), .rst_i(rst),
    .per_slave_r_valid_o(r_valid_o), .per_slave_r_opc_o(r_opc_o),
    .per_slave_r_id_o(r_id_o), .per_slave_r_rdata_o(r_rdata_o),
    .trans_req_i(treq), .trans_id_i(tid), .trans_add_i(tadd),
    .axi_master_r_valid_i(rv), .axi_master_r_data_i(rdata), .axi_master_r_resp_i(rresp),
    .axi_master_r_last_i(rlast), .axi_master_r_id_i(rid), .axi_master_r_user_i(ruser),
    .axi_master_r_ready_o(r_ready_o),
    .axi_master_b_valid_i(bv), .axi_master_b_resp_i(bresp), .axi_master_b_id_i(bid),
    .axi_master_b_user_i(buser), .axi_master_b_ready_o(b_ready_o),
    .unexp_r_o(unexp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        treq;  logic [2:0] tid;  logic [31:0] tadd;
    logic        rv;    logic [2:0] rid;  logic [63:0] rdata; logic [1:0] rresp;
    logic        bv;    logic [2:0] bid;  logic [1:0]  bresp;
    logic        e_bready;
    logic        e_valid; logic [4:0] e_id; logic [31:0] e_rdata; logic e_opc; logic e_unexp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    treq = 0; tid = 0; tadd = 0; rv = 0; rid = 0; rdata = 0; rresp = 0;
    bv = 0; bid = 0; bresp = 0;
  endtask

  task automatic check_out(input logic ev, input logic [4:0] eid, input logic [31:0] ed,
                           input logic eo, input logic eu);
    chk("r_valid", 64'(r_valid_o), 64'(ev));
    chk("unexp", 64'(unexp_o), 64'(eu));
    if (ev) begin
      chk("r_id", 64'(r_id_o), 64'(eid));
      chk("r_rdata", 64'(r_rdata_o), 64'(ed));
      chk("r_opc", 64'(r_opc_o), 64'(eo));
    end
  endtask

  // Random-phase reference state: per-ID lane and outstanding flag
  bit m_lane[8];
  bit m_pend[8];

  initial begin
    rlast = 1'b1; ruser = 6'h2a; buser = 6'h15;
    idle();
    rst = 1'b1;
    #1;
    chk("reset r_valid", 64'(r_valid_o), 64'd0);
    chk("reset r_ready", 64'(r_ready_o), 64'd0);
    chk("reset b_ready", 64'(b_ready_o), 64'd0);
    chk("reset rdata", 64'(r_rdata_o), 64'd0);
    chk("reset id", 64'(r_id_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("r_ready after reset", 64'(r_ready_o), 64'd1);

    vecs[0]  = '{1'b1,3'd2,32'h1000_0004, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[1]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[2]  = '{1'b0,3'd0,32'h0, 1'b1,3'd2,64'hAAAA_BBBB_CCCC_DDDD,2'b00, 1'b0,3'd0,2'b00, 1'b0, 1'b1,5'b00100,32'hAAAA_BBBB,1'b0,1'b0};
    vecs[3]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,64'h0,2'b00, 1'b1,3'd1,2'b10, 1'b1, 1'b1,5'b00010,32'h0,1'b1,1'b0};
    vecs[4]  = '{1'b1,3'd0,32'h0000_0000, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[5]  = '{1'b1,3'd4,32'h8000_0004, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[6]  = '{1'b0,3'd0,32'h0, 1'b1,3'd0,64'h1111_2222_0000_1234,2'b00, 1'b1,3'd3,2'b00, 1'b0, 1'b1,5'b00001,32'h0000_1234,1'b0,1'b0};
    vecs[7]  = '{1'b0,3'd0,32'h0, 1'b0,3'd0,64'h0,2'b00, 1'b1,3'd3,2'b00, 1'b1, 1'b1,5'b01000,32'h0,1'b0,1'b0};
    vecs[8]  = '{1'b1,3'd4,32'h0, 1'b1,3'd4,64'hDEAD_BEEF_0BAD_F00D,2'b00, 1'b0,3'd0,2'b00, 1'b0, 1'b1,5'b10000,32'hDEAD_BEEF,1'b0,1'b0};
    vecs[9]  = '{1'b0,3'd0,32'h0, 1'b1,3'd4,64'h1234_5678_9ABC_DEF0,2'b11, 1'b0,3'd0,2'b00, 1'b0, 1'b1,5'b10000,32'h9ABC_DEF0,1'b1,1'b0};
    vecs[10] = '{1'b1,3'd6,32'h4, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[11] = '{1'b0,3'd0,32'h0, 1'b1,3'd6,64'hFFFF_FFFF_FFFF_FFFF,2'b00, 1'b0,3'd0,2'b00, 1'b0, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[12] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,64'h0,2'b00, 1'b1,3'd7,2'b10, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[13] = '{1'b0,3'd0,32'h0, 1'b1,3'd3,64'h5555_6666_7777_8888,2'b10, 1'b0,3'd0,2'b00, 1'b0, 1'b1,5'b01000,32'h7777_8888,1'b1,1'b1};
    vecs[14] = '{1'b0,3'd0,32'h0, 1'b0,3'd0,64'h0,2'b00, 1'b0,3'd0,2'b00, 1'b1, 1'b0,5'b0,32'h0,1'b0,1'b0};
    vecs[15] = '{1'b0,3'd0,32'h0, 1'b1,3'd2,64'hAAAA_0000_BBBB_0000,2'b00, 1'b0,3'd0,2'b00, 1'b0, 1'b1,5'b00100,32'hBBBB_0000,1'b0,1'b1};

    for (int i = 0; i < 16; i++) begin
      treq = vecs[i].treq; tid = vecs[i].tid; tadd = vecs[i].tadd;
      rv = vecs[i].rv; rid = vecs[i].rid; rdata = vecs[i].rdata; rresp = vecs[i].rresp;
      bv = vecs[i].bv; bid = vecs[i].bid; bresp = vecs[i].bresp;
      #1;
      chk($sformatf("v%0d b_ready", i), 64'(b_ready_o), 64'(vecs[i].e_bready));
      @(posedge clk); #1;
      idle();
      check_out(vecs[i].e_valid, vecs[i].e_id, vecs[i].e_rdata, vecs[i].e_opc, vecs[i].e_unexp);
    end

    // Async reset landing between edges while a response is on the outputs
    treq = 1; tid = 2; tadd = 32'h4;
    @(posedge clk); #1;
    idle(); rv = 1; rid = 2; rdata = 64'h0102_0304_0506_0708;
    @(posedge clk); #1;
    idle();
    check_out(1'b1, 5'b00100, 32'h0102_0304, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid-reset r_valid", 64'(r_valid_o), 64'd0);
    chk("mid-reset rdata", 64'(r_rdata_o), 64'd0);
    chk("mid-reset id", 64'(r_id_o), 64'd0);
    chk("mid-reset r_ready", 64'(r_ready_o), 64'd0);
    chk("mid-reset b_ready", 64'(b_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv = 1; rid = 2; rdata = 64'h1111_1111_2222_2222;
    @(posedge clk); #1;
    idle();
    check_out(1'b1, 5'b00100, 32'h2222_2222, 1'b0, 1'b1);

    // Random traffic against the per-ID reference
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin m_lane[k] = 0; m_pend[k] = 0; end
    begin
      logic        e_valid, e_opc, e_unexp, b_taken;
      logic [4:0]  e_id;
      logic [31:0] e_rdata;
      b_taken = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        treq = ($urandom_range(0, 2) == 0);
        tid  = 3'($urandom);
        tadd = $urandom;
        rv   = ($urandom_range(0, 1) == 1);
        rid  = 3'($urandom);
        rdata = {$urandom, $urandom};
        rresp = 2'($urandom);
        if (!bv || b_taken) begin
          bv = ($urandom_range(0, 2) == 0);
          bid = 3'($urandom);
          bresp = 2'($urandom);
        end
        e_valid = 0; e_unexp = 0; e_opc = 0; e_id = 0; e_rdata = 0;
        if (rv) begin
          e_unexp = !m_pend[rid];
          if (rid < 5) begin
            e_valid = 1; e_id = 5'(1 << rid); e_opc = rresp[1];
            e_rdata = (m_pend[rid] && m_lane[rid]) ? rdata[63:32] : rdata[31:0];
          end
          m_pend[rid] = 0;
        end else if (bv && bid < 5) begin
          e_valid = 1; e_id = 5'(1 << bid); e_opc = bresp[1]; e_rdata = 0;
        end
        if (treq) begin
          m_lane[tid] = tadd[2];
          m_pend[tid] = 1;
        end
        b_taken = bv && !rv;
        #1;
        chk("rnd b_ready", 64'(b_ready_o), 64'(!rv));
        @(posedge clk); #1;
        check_out(e_valid, e_id, e_rdata, e_opc, e_unexp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
